// File: rtl/pc_sequencer_if.sv
// Sequencer-side bundle: instruction-memory handshake, decoded control inputs,
// return-stack strobes and status. master = sequencer, slave = environment.
interface pc_sequencer_if #(
   parameter int unsigned AW    = 12,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned DW = $clog2(DEPTH) + 1;

   logic          imem_req;
   logic          imem_ready;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic          call;
   logic          ret;
   logic          jump;
   logic          branch_taken;
   logic          halt;
   logic [AW-1:0] target;
   logic [AW-1:0] ret_addr;
   logic          stack_push;
   logic          stack_pop;
   logic [AW-1:0] stack_addr;
   logic [DW-1:0] depth;
   logic          overflow;
   logic          underflow;
   logic          halted;

   modport master (
      output imem_req, instr_valid, pc, stack_push, stack_pop, stack_addr,
             depth, overflow, underflow, halted,
      input  imem_ready, call, ret, jump, branch_taken, halt, target, ret_addr
   );

   modport slave (
      input  imem_req, instr_valid, pc, stack_push, stack_pop, stack_addr,
             depth, overflow, underflow, halted,
      output imem_ready, call, ret, jump, branch_taken, halt, target, ret_addr
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter / next-address unit for a fixed-depth return-address stack.
// FETCH waits on imem_ready, EXEC resolves one control action per instruction,
// HALT is absorbing. Stack over/underflow is trapped with sticky flags.
module pc_sequencer #(
   parameter int unsigned   AW       = 12,
   parameter int unsigned   DEPTH    = 8,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.master bus
);
   localparam int unsigned   DW       = $clog2(DEPTH) + 1;
   localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

   typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

   state_e        r_state;
   logic [AW-1:0] r_pc;
   logic [DW-1:0] r_depth;
   logic          r_overflow;
   logic          r_underflow;

   logic [AW-1:0] w_pc_inc;
   logic          w_exec;
   logic          w_stack_full;
   logic          w_stack_empty;
   logic          w_do_ret;
   logic          w_do_call;

   // Next-address and stack-condition decode; priority halt > ret > call.
   always_comb begin
      w_pc_inc      = r_pc + AW'(1);
      w_exec        = (r_state == StExec);
      w_stack_full  = (r_depth == DEPTH_MAX);
      w_stack_empty = (r_depth == '0);
      w_do_ret      = ~bus.halt & bus.ret;
      w_do_call     = ~bus.halt & ~bus.ret & bus.call;
   end

   // Sequencer state, PC, stack depth and sticky trap flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StFetch;
         r_pc        <= RESET_PC;
         r_depth     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         unique case (r_state)
            StFetch: begin
               if (bus.imem_ready) r_state <= StExec;
            end
            StExec: begin
               r_state <= StFetch;
               if (bus.halt) begin
                  r_state <= StHalt;
               end else if (w_do_ret) begin
                  if (!w_stack_empty) begin
                     r_pc    <= bus.ret_addr;
                     r_depth <= r_depth - DW'(1);
                  end else begin
                     r_underflow <= 1'b1;
                     r_pc        <= w_pc_inc;
                  end
               end else if (w_do_call) begin
                  if (!w_stack_full) begin
                     r_pc    <= bus.target;
                     r_depth <= r_depth + DW'(1);
                  end else begin
                     r_overflow <= 1'b1;
                     r_pc       <= w_pc_inc;
                  end
               end else if (bus.jump || bus.branch_taken) begin
                  r_pc <= bus.target;
               end else begin
                  r_pc <= w_pc_inc;
               end
            end
            StHalt: r_state <= StHalt;
            default: r_state <= StFetch;
         endcase
      end
   end

   // Outputs: status decoded from registered state; strobes are combinational
   // in EXEC so the stack updates on the same edge as the PC.
   always_comb begin
      bus.imem_req    = (r_state == StFetch) & ~rst;
      bus.instr_valid = w_exec;
      bus.halted      = (r_state == StHalt);
      bus.pc          = r_pc;
      bus.depth       = r_depth;
      bus.overflow    = r_overflow;
      bus.underflow   = r_underflow;
      bus.stack_addr  = w_pc_inc;
      bus.stack_push  = w_exec & w_do_call & ~w_stack_full;
      bus.stack_pop   = w_exec & w_do_ret & ~w_stack_empty;
   end
endmodule
